// File: rtl/tff_seq_ctrl.sv
// rtl/tff_seq_ctrl.sv - toggle-flop bank sequencer: clears, counts up to a latched limit, pauses/aborts
//
// Purpose: drives a WIDTH-bit bank of toggle flops (q <= q ^ t_vec) through
//          IDLE -> CLEAR -> RUN -> DONE, with PAUSE entered from RUN by stop.
// Ports:
//   clk    - clock, all state on rising edge
//   rst    - synchronous active-high reset
//   start  - launch (IDLE) / resume (PAUSE)
//   stop   - pause (RUN) / abort (PAUSE)
//   limit  - terminal count, latched when start is accepted in IDLE
//   t_vec  - combinational toggle command applied this cycle
//   q, qb  - flop bank state and its complement
//   busy   - high in CLEAR, RUN, PAUSE
//   done   - high in DONE (or on the terminal RUN cycle in the auto-reload build)
// Build option: TFF_SEQ_AUTORELOAD_EN - wrap back to 0 at the terminal count
//               instead of finishing; the port list is identical in both builds.
module tff_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] lim_r;
    logic             lim_load;
    logic [WIDTH-1:0] inc_pat;

    // Synchronous-counter toggle pattern: bit i toggles when all lower bits are 1.
    always_comb begin
        logic carry;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            inc_pat[i] = carry;
            carry      = carry & q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            q     <= '0;
            lim_r <= '0;
        end else begin
            state <= state_nxt;
            q     <= q ^ t_vec;
            if (lim_load) begin
                lim_r <= limit;
            end
        end
    end

    assign qb = ~q;

    always_comb begin
        state_nxt = state;
        t_vec     = '0;
        lim_load  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !stop) begin
                    lim_load  = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy      = 1'b1;
                t_vec     = q;      // toggling every set bit clears the bank
                state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                // stop outranks the terminal-count check
                if (stop) begin
                    state_nxt = S_PAUSE;
                end else if (q == lim_r) begin
`ifdef TFF_SEQ_AUTORELOAD_EN
                    t_vec = q;      // wrap to 0 and keep running
                    done  = 1'b1;
`else
                    state_nxt = S_DONE;
`endif
                end else begin
                    t_vec = inc_pat;
                end
            end
            S_PAUSE: begin
                busy = 1'b1;
                if (stop) begin
                    state_nxt = S_IDLE;
                end else if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tff_seq_ctrl.sv
// tb/tb_tff_seq_ctrl.sv - self-checking bench for tff_seq_ctrl with a per-cycle reference model
module tb_tff_seq_ctrl;

    localparam int W    = 4;
    localparam int MAXQ = (1 << W) - 1;

    localparam int P_IDLE  = 0;
    localparam int P_CLEAR = 1;
    localparam int P_RUN   = 2;
    localparam int P_PAUSE = 3;
    localparam int P_DONE  = 4;

`ifdef TFF_SEQ_AUTORELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] limit = '0;
    logic [W-1:0] t_vec;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    tff_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .limit (limit),
        .t_vec (t_vec),
        .q     (q),
        .qb    (qb),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase, counter value and latched limit as plain integers.
    int m_phase = P_IDLE;
    int m_q     = 0;
    int m_lim   = 0;
    bit m_valid = 1'b0;

    function automatic void model_next(input int ph, input int cq, input int lim,
                                       input logic st, input logic sp, input int lm,
                                       output int nph, output int nq, output int nlim);
        nph  = ph;
        nq   = cq;
        nlim = lim;
        case (ph)
            P_IDLE:  if (st && !sp) begin nph = P_CLEAR; nlim = lm; end
            P_CLEAR: begin nq = 0; nph = P_RUN; end
            P_RUN: begin
                if (sp)              nph = P_PAUSE;
                else if (cq == lim)  begin if (RELOAD) nq = 0; else nph = P_DONE; end
                else                 nq = cq + 1;
            end
            P_PAUSE: begin
                if (sp)      nph = P_IDLE;
                else if (st) nph = P_RUN;
            end
            default: nph = P_IDLE;
        endcase
    endfunction

    always @(posedge clk) begin
        int nph, nq, nlim;
        if (rst) begin
            m_phase = P_IDLE;
            m_q     = 0;
            m_lim   = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            model_next(m_phase, m_q, m_lim, start, stop, int'(limit), nph, nq, nlim);
            m_phase = nph;
            m_q     = nq;
            m_lim   = nlim;
        end
    end

    // Compare process: outputs are checked mid-cycle against the model.
    always @(negedge clk) begin
        int nph, nq, nlim, e_busy, e_done;
        if (m_valid && !rst) begin
            model_next(m_phase, m_q, m_lim, start, stop, int'(limit), nph, nq, nlim);
            e_busy = (m_phase == P_CLEAR || m_phase == P_RUN || m_phase == P_PAUSE) ? 1 : 0;
            e_done = (m_phase == P_DONE ||
                      (RELOAD && m_phase == P_RUN && !stop && m_q == m_lim)) ? 1 : 0;
            chk("cyc_t_vec", int'(t_vec), m_q ^ nq);
            chk("cyc_q",     int'(q),     m_q);
            chk("cyc_qb",    int'(qb),    MAXQ - m_q);
            chk("cyc_busy",  int'(busy),  e_busy);
            chk("cyc_done",  int'(done),  e_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int seq[$];
    int first_done;
    int done_cnt;

    task automatic collect(input int n);
        seq.delete();
        first_done = -1;
        done_cnt   = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (busy) seq.push_back(int'(q));
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = i;
            end
        end
    endtask

    // Launch with lim, then scramble limit to show the latched copy is used.
    task automatic run_seq(input int lim, input int n);
        limit = W'(lim);
        start = 1'b1;
        tick();
        start = 1'b0;
        limit = W'(~lim);
        collect(n);
    endtask

    task automatic wait_q(input int v);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (int'(q) == v) hit = 1'b1;
        end
        chk("wait_q_reached", int'(hit), 1);
    endtask

    task automatic chk_seq(input string name, input int lo, input int hi);
        chk({name, "_len"}, seq.size(), hi - lo + 1);
        for (int i = 0; i < seq.size() && i <= hi - lo; i++)
            chk({name, "_val"}, seq[i], lo + i);
    endtask

    initial begin
        // Reset held two cycles with start asserted
        rst   = 1'b1;
        start = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_q", int'(q), 0);
        chk("rst_qb", int'(qb), 'hF);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_t_vec", int'(t_vec), 0);

        // start together with stop in IDLE is ignored
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("idle_start_stop_busy", int'(busy), 0);

`ifndef TFF_SEQ_AUTORELOAD_EN
        // One-shot to 5
        run_seq(5, 14);
        chk_seq("oneshot_seq", 0, 5);
        chk("oneshot_done_edge", first_done, 7);
        chk("oneshot_done_cnt", done_cnt, 1);
        chk("oneshot_q_hold", int'(q), 5);

        // Pause at 3, then resume to 9
        limit = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_q(3);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("pause_q", int'(q), 3);
        chk("pause_busy", int'(busy), 1);
        tick();
        tick();
        chk("pause_hold_q", int'(q), 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        collect(12);
        chk_seq("resume_seq", 4, 9);
        chk("resume_done_cnt", done_cnt, 1);
        chk("resume_q_hold", int'(q), 9);

        // Abort from PAUSE with stop held two cycles
        limit = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_q(2);
        stop = 1'b1;
        tick();
        tick();
        stop = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_q", int'(q), 2);
        tick();
        tick();
        chk("abort_q_hold", int'(q), 2);
        chk("abort_done", int'(done), 0);

        // limit = 0
        run_seq(0, 6);
        chk_seq("lim0_seq", 0, 0);
        chk("lim0_done_edge", first_done, 2);
        chk("lim0_done_cnt", done_cnt, 1);

        // limit = all ones: no wrap
        run_seq(15, 22);
        chk_seq("limF_seq", 0, 15);
        chk("limF_done_edge", first_done, 17);
        chk("limF_q", int'(q), 15);

        // Reset mid-RUN at q=6, then a normal run to 2
        limit = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_q(6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_q", int'(q), 0);
        chk("midrst_busy", int'(busy), 0);
        run_seq(2, 8);
        chk_seq("after_rst_seq", 0, 2);
        chk("after_rst_done_edge", first_done, 4);
        chk("after_rst_q", int'(q), 2);
`else
        // Auto-reload: 0,1,2 repeating with done on each q=2 cycle
        run_seq(2, 9);
        chk("reload_len", seq.size(), 9);
        for (int i = 0; i < seq.size() && i < 9; i++)
            chk("reload_val", seq[i], i % 3);
        chk("reload_done_edge", first_done, 3);
        chk("reload_done_cnt", done_cnt, 3);
        stop = 1'b1;
        tick();
        chk("reload_pause_busy", int'(busy), 1);
        tick();
        stop = 1'b0;
        chk("reload_abort_busy", int'(busy), 0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/tff_seq_ctrl.md
TFF_SEQ_CTRL -- requirements
Module: tff_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the number of toggle-flop bits sequenced (legal range 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-004 SHALL have port start, input, 1, a level that launches a sequence (IDLE) or resumes one (PAUSE).
REQ-005 SHALL have port stop, input, 1, a level that pauses (RUN) or aborts (PAUSE).
REQ-006 SHALL have port limit, input, WIDTH, the terminal count, latched when start is accepted in IDLE.
REQ-007 SHALL have port t_vec, output, WIDTH, the combinational toggle command vector applied to the flop bank this cycle.
REQ-008 SHALL have port q, output, WIDTH, the toggle-flop bank state.
REQ-009 SHALL have port qb, output, WIDTH, always equal to ~q.
REQ-010 SHALL have port busy, output, 1, high in states CLEAR, RUN and PAUSE.
REQ-011 SHALL have port done, output, 1, high only in state DONE.

Function
REQ-012 SHALL hold an internal WIDTH-bit toggle-flop bank; each clk edge applies q <= q ^ t_vec.
REQ-013 SHALL implement FSM states IDLE, CLEAR, RUN, PAUSE and DONE.
REQ-014 IDLE SHALL drive t_vec=0; start=1 and stop=0 SHALL latch limit into lim_r and go to CLEAR.
REQ-015 CLEAR SHALL drive t_vec=q, so q becomes 0 at the next edge, and SHALL go unconditionally to RUN.
REQ-016 RUN with q!=lim_r and stop=0 SHALL drive the synchronous-counter increment pattern: t_vec[0]=1, and t_vec[i]=&q[i-1:0] for i>0.
REQ-017 RUN with q==lim_r and stop=0 SHALL drive t_vec=0 and go to DONE.
REQ-018 RUN with stop=1 SHALL drive t_vec=0 and go to PAUSE; stop SHALL take priority over the terminal-count check.
REQ-019 PAUSE SHALL drive t_vec=0 and hold q.
REQ-020 PAUSE with stop=1 SHALL go to IDLE (abort, q held); with stop=0 and start=1 SHALL go to RUN; otherwise SHALL stay in PAUSE.
REQ-021 DONE SHALL drive t_vec=0 for exactly one cycle and then go to IDLE; q SHALL hold lim_r in DONE and in the following IDLE.
REQ-022 Latency: with start accepted at edge E0, q SHALL be 0 after E1 and reach lim_r after edge E(lim_r+1); done SHALL be high during the cycle following edge E(lim_r+2).
REQ-023 limit=0 SHALL go CLEAR -> RUN -> DONE with q=0 throughout (one RUN cycle, no increment).
REQ-024 start=1 with stop=1 in IDLE SHALL be ignored; start SHALL be ignored in CLEAR, RUN and DONE.
REQ-025 Changes on limit after acceptance SHALL NOT affect the running sequence.
REQ-026 lim_r=2^WIDTH-1 SHALL terminate at all-ones; q SHALL never wrap in RUN.

Reset
REQ-027 rst=1 SHALL force state=IDLE, q=0, qb=all ones, lim_r=0, busy=0 and done=0 at the next edge, overriding all other inputs in any state.
REQ-028 After reset, t_vec SHALL be 0 (IDLE).

Configuration
REQ-029 Macro TFF_SEQ_AUTORELOAD_EN, when defined, SHALL replace the RUN terminal action: at q==lim_r with stop=0, the block drives t_vec=q, stays in RUN and asserts done for that single cycle (state DONE is unreachable), so the sequence repeats 0..lim_r until stop.
REQ-030 Without TFF_SEQ_AUTORELOAD_EN, the behaviour SHALL be REQ-017 and REQ-021 (one-shot); the port list SHALL be identical in both builds.

Verification
REQ-031 Reset: hold rst=1 for 2 cycles with start=1 -> q=0, qb=4'hF, busy=0, done=0, t_vec=0.
REQ-032 One-shot: limit=5, pulse start for 1 cycle -> q sequence 0,1,2,3,4,5; done high exactly one cycle, 8 edges after start is accepted; q holds 5 afterward.
REQ-033 Pause/resume: limit=9, assert stop while q=3 -> q holds 3, busy=1; then start=1 with stop=0 -> q continues 4..9 and done pulses once.
REQ-034 Abort and boundaries: stop held 2 cycles in PAUSE -> IDLE with q held; limit=0 -> done after 3 edges with q=0; limit=4'hF -> q reaches F with no wrap.
REQ-035 Reset mid-RUN at q=6 -> q=0 and IDLE next edge; a later start with limit=2 completes normally.
REQ-036 With TFF_SEQ_AUTORELOAD_EN, limit=2 -> q sequence 0,1,2,0,1,2..., with done high on every q=2 cycle until stop.
